// File: rtl/aes_pkg.sv
// aes_pkg: types, constants and helper functions shared by the AES blocks.
//   key_t / word_t / byte_t : 128-, 32- and 8-bit views of the AES state.
//   NUM_ROUNDS              : index of the final AES-128 round key.
//   RCON_INIT               : round constant that derives round key 1.
//   xtime()                 : multiply by x in GF(2^8), modulo x^8+x^4+x^3+x+1.
//   sbox()                  : forward AES S-box lookup.
package aes_pkg;

  typedef logic [127:0] key_t;
  typedef logic [31:0]  word_t;
  typedef logic [7:0]   byte_t;

  localparam int    NUM_ROUNDS = 10;
  localparam byte_t RCON_INIT  = 8'h01;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t sbox(input byte_t b);
    byte_t s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward AES S-box, one byte per instance.
// Ports:
//   din   in  8  input byte
//   dout  out 8  substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t din,
  output byte_t dout
);

  assign dout = sbox(din);

endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: on-the-fly AES-128 key expansion. A load captures the
// cipher key as round key 0; each step while busy derives the next round key
// from the current one, up to round key NR. Only the current key is stored.
// Ports:
//   clk         in  1    clock, rising edge
//   rst         in  1    asynchronous active-high reset
//   load        in  1    capture key_in as round key 0 (wins over step)
//   key_in      in  128  cipher key, byte 0 in [127:120]
//   step        in  1    advance to the next round key while busy
//   round_key   out 128  current round key (registered)
//   round_idx   out 4    index of round_key, 0..NR
//   rcon        out 8    Rcon that will derive round key round_idx+1
//   busy        out 1    high from load until round key NR is reached
//   last_round  out 1    round_idx == NR
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int   NR        = NUM_ROUNDS,  // only 10 (AES-128) is meaningful
  parameter key_t RESET_KEY = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] key_in,
  input  logic         step,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic [7:0]   rcon,
  output logic         busy,
  output logic         last_round
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  word_t w0, w1, w2, w3;
  word_t rot_word, sub_word, t_word;
  word_t n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = round_key;

  // RotWord: the top byte of w3 moves to the bottom.
  assign rot_word = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .din  (rot_word[8*i +: 8]),
      .dout (sub_word[8*i +: 8])
    );
  end

  assign t_word = sub_word ^ {rcon, 24'h0};

  // Each new word chains off the one just produced, not the old key.
  assign n0 = w0 ^ t_word;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign last_round = (round_idx == LAST_IDX);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; blocking here would let the XOR chain see
  // half-updated state in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_key <= RESET_KEY;
      round_idx <= '0;
      rcon      <= RCON_INIT;
      busy      <= 1'b0;
    end else if (load) begin
      round_key <= key_in;
      round_idx <= '0;
      rcon      <= RCON_INIT;
      busy      <= 1'b1;
    end else if (step && busy) begin
      round_key <= {n0, n1, n2, n3};
      round_idx <= round_idx + 4'd1;
      rcon      <= xtime(rcon);
      // Drop busy on the edge that lands on the final index, so a held step
      // can never push round_idx past NR.
      busy      <= (round_idx != LAST_IDX - 4'd1);
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: directed test of aes_key_schedule against the FIPS-197
// A.1 expansion, the all-zero-key expansion, stalls, restart, saturation and
// asynchronous reset.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [127:0] key_in;
  logic         step;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic [7:0]   rcon;
  logic         busy;
  logic         last_round;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] key_tab  [0:10];
  logic [7:0]   rcon_tab [0:9];
  logic [127:0] zero_tab [0:2];

  aes_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .key_in     (key_in),
    .step       (step),
    .round_key  (round_key),
    .round_idx  (round_idx),
    .rcon       (rcon),
    .busy       (busy),
    .last_round (last_round)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge, then return on the falling edge where inputs are driven
  // and outputs sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_state(input string tag, input logic [127:0] k, input int idx);
    check({tag, ".key"}, round_key, k);
    check({tag, ".idx"}, 128'(round_idx), 128'(idx));
  endtask

  initial begin
    key_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    key_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    key_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    key_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    key_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    key_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    key_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    key_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    key_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    key_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rcon_tab[0] = 8'h01; rcon_tab[1] = 8'h02; rcon_tab[2] = 8'h04; rcon_tab[3] = 8'h08;
    rcon_tab[4] = 8'h10; rcon_tab[5] = 8'h20; rcon_tab[6] = 8'h40; rcon_tab[7] = 8'h80;
    rcon_tab[8] = 8'h1b; rcon_tab[9] = 8'h36;
    zero_tab[0] = 128'h0;
    zero_tab[1] = 128'h62636363626363636263636362636363;
    zero_tab[2] = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

    rst = 1'b1; load = 1'b0; step = 1'b0; key_in = '0;
    #12;
    @(negedge clk);

    // Reset values.
    check_state("rst", 128'h0, 0);
    check("rst.rcon", 128'(rcon), 128'h01);
    check("rst.busy", 128'(busy), 128'h0);
    check("rst.last", 128'(last_round), 128'h0);
    rst = 1'b0;

    // Step without a prior load does nothing.
    step = 1'b1;
    repeat (3) tick();
    check_state("noload", 128'h0, 0);
    check("noload.busy", 128'(busy), 128'h0);

    // FIPS-197 A.1 with step held high; load and step share the first edge.
    load = 1'b1; key_in = key_tab[0];
    tick();
    load = 1'b0; key_in = '1;  // key_in is ignored outside load edges
    check_state("a1.k0", key_tab[0], 0);
    check("a1.busy0", 128'(busy), 128'h1);
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("a1.rcon%0d", k - 1), 128'(rcon), 128'(rcon_tab[k - 1]));
      check($sformatf("a1.last%0d", k - 1), 128'(last_round), 128'h0);
      tick();
      check_state($sformatf("a1.k%0d", k), key_tab[k], k);
    end
    check("a1.last10", 128'(last_round), 128'h1);
    check("a1.busy10", 128'(busy), 128'h0);

    // Saturation: five more step cycles change nothing.
    repeat (5) tick();
    check_state("sat", key_tab[10], 10);
    check("sat.last", 128'(last_round), 128'h1);

    // Load with step high on the same edge: load wins.
    load = 1'b1; key_in = key_tab[0];
    tick();
    load = 1'b0;
    check_state("sat.reload", key_tab[0], 0);
    check("sat.reload.busy", 128'(busy), 128'h1);

    // Stalls: random step gaps must yield the same sequence; hold on step=0.
    step = 1'b0; load = 1'b1; key_in = key_tab[0];
    tick();
    load = 1'b0;
    begin
      int exp_idx = 0;
      for (int cyc = 0; cyc < 200 && exp_idx < 10; cyc++) begin
        step = 1'($urandom_range(0, 1));
        tick();
        if (step) exp_idx++;
        check_state($sformatf("stall.c%0d", cyc), key_tab[exp_idx], exp_idx);
      end
      step = 1'b0;
      check("stall.last", 128'(last_round), 128'h1);
    end

    // Restart: reach round 5, then load an all-zero key mid-expansion.
    load = 1'b1; key_in = key_tab[0]; step = 1'b1;
    tick();
    load = 1'b0;
    repeat (5) tick();
    check_state("rs.k5", key_tab[5], 5);
    load = 1'b1; key_in = '0;
    tick();
    load = 1'b0;
    check_state("rs.z0", zero_tab[0], 0);
    check("rs.rcon", 128'(rcon), 128'h01);
    check("rs.busy", 128'(busy), 128'h1);
    tick();
    check_state("rs.z1", zero_tab[1], 1);
    tick();
    check_state("rs.z2", zero_tab[2], 2);

    // Asynchronous reset mid-expansion, away from any clock edge.
    #2 rst = 1'b1;
    #1;
    check_state("arst", 128'h0, 0);
    check("arst.rcon", 128'(rcon), 128'h01);
    check("arst.busy", 128'(busy), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    check_state("arst.hold", 128'h0, 0);
    check("arst.hold.busy", 128'(busy), 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
